// File: rtl/alu_cmd_sequencer.sv
// Command FIFO plus sequencer that replays host ALU requests as load/persist/reset cycles.
// Optional build macro ALU_SEQ_STATS_EN enables the issue_count statistics counter.
module alu_cmd_sequencer #(
  parameter int DATA_W      = 8,
  parameter int OP_W        = 7,
  parameter int FIFO_DEPTH  = 4,
  parameter int EXEC_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_clear,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic [DATA_W-1:0] num1,
  output logic [DATA_W-1:0] num2,
  output logic [2:0]        in_sel,
  output logic [OP_W-1:0]   out_sel,
  output logic              on,
  output logic              busy,
  output logic              err_bad_op,
  output logic [7:0]        issue_count
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int ENT_W = 2*DATA_W + 4;
  localparam int CNT_W = $clog2(EXEC_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_CLEAR} state_t;

  logic [ENT_W-1:0]  r_mem [FIFO_DEPTH];
  logic [AW:0]       r_wr_ptr, r_rd_ptr;
  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_num1, r_num2;
  logic [2:0]        r_in_sel;
  logic [OP_W-1:0]   r_out_sel;
  logic              r_on, r_err;

  logic [AW:0]       w_count;
  logic              w_bad_op, w_accept, w_push, w_pop_slot, w_pop;
  logic [ENT_W-1:0]  w_head;
  logic              w_head_clr;
  logic [2:0]        w_head_op;
  logic [DATA_W-1:0] w_head_a, w_head_b;

  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign cmd_ready  = (w_count != (AW+1)'(FIFO_DEPTH));
  assign w_bad_op   = !cmd_clear && ({1'b0, cmd_op} >= 4'(OP_W));
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_push     = w_accept && !w_bad_op;

  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
  assign w_head_clr = w_head[ENT_W-1];
  assign w_head_op  = w_head[2*DATA_W +: 3];
  assign w_head_a   = w_head[DATA_W +: DATA_W];
  assign w_head_b   = w_head[0 +: DATA_W];

  // Pop when idle, or on the final cycle of a sequence so the next one starts without a bubble.
  assign w_pop_slot = (r_state == S_IDLE) || (r_state == S_CLEAR) ||
                      ((r_state == S_EXEC) && (r_cnt == CNT_W'(1)));
  assign w_pop      = w_pop_slot && (w_count != '0);

  assign busy       = (r_state != S_IDLE) || (w_count != '0);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {cmd_clear, cmd_op, cmd_a, cmd_b};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_num1    <= '0;
      r_num2    <= '0;
      r_in_sel  <= 3'b000;
      r_out_sel <= '0;
      r_on      <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_on <= 1'b1;
      if (w_accept && w_bad_op) r_err <= 1'b1;
      if (w_pop) begin
        if (w_head_clr) begin
          r_state   <= S_CLEAR;
          r_in_sel  <= 3'b001;
          r_out_sel <= '0;
          r_num1    <= '0;
          r_num2    <= '0;
        end else begin
          r_state   <= S_LOAD;
          r_in_sel  <= 3'b010;
          r_out_sel <= OP_W'(1) << w_head_op;
          r_num1    <= w_head_a;
          r_num2    <= w_head_b;
        end
      end else begin
        case (r_state)
          S_LOAD: begin
            r_state  <= S_EXEC;
            r_in_sel <= 3'b100;
            r_cnt    <= CNT_W'(EXEC_CYCLES);
          end
          S_EXEC: begin
            if (r_cnt != CNT_W'(1)) begin
              r_cnt <= r_cnt - CNT_W'(1);
            end else begin
              r_state   <= S_IDLE;
              r_in_sel  <= 3'b000;
              r_out_sel <= '0;
            end
          end
          default: begin
            r_state   <= S_IDLE;
            r_in_sel  <= 3'b000;
            r_out_sel <= '0;
          end
        endcase
      end
    end
  end

  assign num1       = r_num1;
  assign num2       = r_num2;
  assign in_sel     = r_in_sel;
  assign out_sel    = r_out_sel;
  assign on         = r_on;
  assign err_bad_op = r_err;

`ifdef ALU_SEQ_STATS_EN
  logic [7:0] r_issue;
  // Every pop enters LOAD or CLEAR, so pops are exactly the issued commands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_issue <= 8'd0;
    else if (w_pop) r_issue <= r_issue + 8'd1;
  end
  assign issue_count = r_issue;
`else
  assign issue_count = 8'd0;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Scoreboard bench for alu_cmd_sequencer: stimulus enqueues expected ALU cycles, a monitor pops and compares.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_clear = 1'b0;
  logic [2:0] cmd_op = 3'd0;
  logic [7:0] cmd_a = 8'd0, cmd_b = 8'd0;
  logic [7:0] num1, num2;
  logic [2:0] in_sel;
  logic [6:0] out_sel;
  logic       on, busy, err_bad_op;
  logic [7:0] issue_count;

  alu_cmd_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_clear(cmd_clear), .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .num1(num1), .num2(num2), .in_sel(in_sel), .out_sel(out_sel), .on(on),
    .busy(busy), .err_bad_op(err_bad_op), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] sel;
    logic [6:0] osel;
    logic [7:0] n1;
    logic [7:0] n2;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   exp_issue = 0;
  int   gap_cnt = 0;
  logic prev_active = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic int exp_ic();
`ifdef ALU_SEQ_STATS_EN
    return exp_issue % 256;
`else
    return 0;
`endif
  endfunction

  always @(negedge clk) begin : monitor
    exp_t got;
    exp_t e;
    if (rst && in_sel != 3'b000) begin
      got = {in_sel, out_sel, num1, num2};
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_issue: got 0x%0h required no output", got);
      end else begin
        e = exp_q.pop_front();
        chk("issue_seq", got, e);
      end
    end
    if (rst && prev_active && in_sel == 3'b000 && busy) gap_cnt++;
    prev_active = rst && (in_sel != 3'b000);
  end

  task automatic push(input bit clr, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_clear = clr; cmd_op = op; cmd_a = a; cmd_b = b;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: cmd_ready got 0 required 1");
    end
    @(posedge clk);
    if (clr) begin
      exp_q.push_back({3'b001, 7'd0, 8'd0, 8'd0});
      exp_issue++;
    end else if (op < 3'd7) begin
      exp_q.push_back({3'b010, 7'd1 << op, a, b});
      exp_q.push_back({3'b100, 7'd1 << op, a, b});
      exp_q.push_back({3'b100, 7'd1 << op, a, b});
      exp_issue++;
    end
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((busy || exp_q.size() != 0) && n < 400);
    chk({name, "_drained"}, 32'(n < 400), 1);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_sel", in_sel, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_num1", num1, 0);
    chk("rst_on", on, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_err", err_bad_op, 0);
    chk("rst_issue", issue_count, 0);
    @(negedge clk) rst = 1'b1;
    #1 chk("on_before_edge", on, 0);
    @(posedge clk);
    #1 chk("on_after_edge", on, 1);

    // Single op: LOAD one edge after acceptance, two persist cycles, then idle
    push(1'b0, 3'd1, 8'h57, 8'h1A);
    chk("t1_busy_pending", busy, 1);
    @(posedge clk);
    #1;
    chk("t1_load_in_sel", in_sel, 3'b010);
    chk("t1_load_out_sel", out_sel, 7'b0000010);
    chk("t1_load_num1", num1, 8'h57);
    chk("t1_load_num2", num2, 8'h1A);
    repeat (3) @(posedge clk);
    #1;
    chk("t1_idle_in_sel", in_sel, 3'b000);
    chk("t1_idle_busy", busy, 0);
    chk("t1_issue", issue_count, exp_ic());

    // Back-to-back pushes fill the FIFO; all ops issue in order without bubbles
    gap_cnt = 0;
    for (int i = 0; i < 6; i++)
      push(1'b0, 3'(i % 7), 8'h10 + 8'(i), 8'hA0 + 8'(i));
    @(negedge clk);
    chk("t2_ready_full", cmd_ready, 0);
    push(1'b0, 3'd6, 8'hC3, 8'h3C);
    drain("t2");
    chk("t2_no_gap", gap_cnt, 0);
    chk("t2_issue", issue_count, exp_ic());

    // Clear between two ops
    gap_cnt = 0;
    push(1'b0, 3'd3, 8'h33, 8'h44);
    push(1'b1, 3'd5, 8'hFF, 8'hFF);
    push(1'b0, 3'd6, 8'hF0, 8'h0F);
    drain("t3");
    chk("t3_no_gap", gap_cnt, 0);

    // Out-of-range op is dropped and flags a sticky error
    push(1'b0, 3'd7, 8'h11, 8'h22);
    chk("t4_err_set", err_bad_op, 1);
    chk("t4_not_written", busy, 0);
    chk("t4_issue_unchanged", issue_count, exp_ic());
    push(1'b0, 3'd2, 8'h81, 8'h7E);
    drain("t4");
    chk("t4_err_sticky", err_bad_op, 1);
    chk("t4_issue", issue_count, exp_ic());

    // Async reset during the second persist cycle with a command still queued
    push(1'b0, 3'd4, 8'hAA, 8'h55);
    push(1'b0, 3'd5, 8'h12, 8'h34);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    exp_q.delete();
    exp_issue = 0;
    #1;
    chk("t5_num1", num1, 0);
    chk("t5_num2", num2, 0);
    chk("t5_in_sel", in_sel, 0);
    chk("t5_out_sel", out_sel, 0);
    chk("t5_on", on, 0);
    chk("t5_err", err_bad_op, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready", cmd_ready, 1);
    chk("t5_issue", issue_count, 0);
    @(negedge clk) rst = 1'b1;
    #1 chk("t5_on_before_edge", on, 0);
    @(posedge clk);
    #1 chk("t5_on_after_edge", on, 1);
    repeat (5) @(negedge clk);
    #1;
    chk("t5_no_stale_in_sel", in_sel, 0);
    chk("t5_no_stale_busy", busy, 0);

    // 257 clears: counter wraps to 1 when enabled, stays 0 otherwise
    for (int i = 0; i < 257; i++)
      push(1'b1, 3'd0, 8'h00, 8'h00);
    drain("t6");
`ifdef ALU_SEQ_STATS_EN
    chk("t6_issue_wrap", issue_count, 1);
`else
    chk("t6_issue_zero", issue_count, 0);
`endif
    chk("t6_issue_model", issue_count, exp_ic());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
